// File: rtl/sipo_deserializer_param.sv
// Serial-in/parallel-out deserializer with selectable bit order, word framing,
// a valid/ready holding register, sticky overrun detection and partial-word flush.
//
// Handshake: q_valid is high while q holds an unconsumed word. A word is
// consumed at a rising edge where q_valid && q_ready; q_ready while q_valid is
// low does nothing. A word completing at the same edge as a consume replaces q
// and keeps q_valid high without flagging overrun. A word completing while
// q_valid is high and q_ready is low overwrites q (newest data wins) and sets
// the sticky overrun flag, which only rst or clr clear.
module sipo_deserializer_param #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1,
   localparam int CW       = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d,
   input  logic             d_en,
   input  logic             clr,
   input  logic             q_ready,
   output logic [WIDTH-1:0] shreg,
   output logic [CW-1:0]    bit_cnt,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             overrun
);

   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] shifted;
   logic             accept;
   logic             complete;
   logic             consume;

   // Next shift-register value and the framing/handshake events of this cycle.
   always_comb begin
      shifted  = '0;
      if (LSB_FIRST) begin
         shifted = {d, shreg[WIDTH-1:1]};
      end else begin
         shifted = {shreg[WIDTH-2:0], d};
      end
      accept   = d_en && !clr;
      complete = accept && (bit_cnt == LAST_CNT);
      consume  = q_valid && q_ready;
   end

   // Shift register and bit counter: flush on clr, otherwise shift on d_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (clr) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (accept) begin
         shreg <= shifted;
         if (complete) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   // Holding register, valid flag and sticky overrun; clr leaves q/q_valid alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         q       <= '0;
         q_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (clr) begin
            overrun <= 1'b0;
         end
         if (complete) begin
            q       <= shifted;
            q_valid <= 1'b1;
            if (q_valid && !q_ready) begin
               overrun <= 1'b1;
            end
         end else if (consume) begin
            q_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_deserializer_param.sv
// Bench for sipo_deserializer_param: one LSB-first and one MSB-first instance
// share the same stimulus and are compared against a bit-history reference model.
module tb_sipo_deserializer_param;

   localparam int W  = 8;
   localparam int CW = $clog2(W);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          d = 1'b0;
   logic          d_en = 1'b0;
   logic          clr = 1'b0;
   logic          q_ready = 1'b0;
   logic [W-1:0]  shreg_a, shreg_b, q_a, q_b;
   logic [CW-1:0] bit_cnt_a, bit_cnt_b;
   logic          q_valid_a, q_valid_b, overrun_a, overrun_b;

   int errors = 0;
   int checks = 0;

   // Reference model: bits accepted since the last flush (most recent W kept),
   // count of accepted bits in the current word, and the handshake state.
   logic         hist[$];
   int           m_cnt = 0;
   logic [W-1:0] m_qa = '0;
   logic [W-1:0] m_qb = '0;
   logic         m_qv = 1'b0;
   logic         m_ov = 1'b0;

   // Clock generation.
   always #5 clk = ~clk;

   sipo_deserializer_param #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst(rst), .d(d), .d_en(d_en), .clr(clr), .q_ready(q_ready),
      .shreg(shreg_a), .bit_cnt(bit_cnt_a), .q(q_a), .q_valid(q_valid_a),
      .overrun(overrun_a)
   );

   sipo_deserializer_param #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .d(d), .d_en(d_en), .clr(clr), .q_ready(q_ready),
      .shreg(shreg_b), .bit_cnt(bit_cnt_b), .q(q_b), .q_valid(q_valid_b),
      .overrun(overrun_b)
   );

   // Register image implied by the bit history: in LSB-first order the k-th
   // most recent bit sits at index W-1-k, in MSB-first order at index k.
   function automatic logic [W-1:0] exp_shreg(input bit lsb);
      logic [W-1:0] r;
      int n;
      r = '0;
      n = hist.size();
      for (int k = 0; k < n; k++) begin
         if (lsb) r[W-1-k] = hist[n-1-k];
         else     r[k]     = hist[n-1-k];
      end
      return r;
   endfunction

   task automatic model_edge();
      logic consume;
      logic complete;
      if (rst) begin
         hist.delete();
         m_cnt = 0; m_qa = '0; m_qb = '0; m_qv = 1'b0; m_ov = 1'b0;
      end else begin
         consume  = m_qv && q_ready;
         complete = 1'b0;
         if (clr) begin
            hist.delete();
            m_cnt = 0;
            m_ov  = 1'b0;
         end else if (d_en) begin
            hist.push_back(d);
            if (hist.size() > W) void'(hist.pop_front());
            m_cnt++;
            if (m_cnt == W) begin
               m_cnt    = 0;
               complete = 1'b1;
            end
         end
         if (complete) begin
            if (m_qv && !q_ready) m_ov = 1'b1;
            m_qv = 1'b1;
            m_qa = exp_shreg(1'b1);
            m_qb = exp_shreg(1'b0);
         end else if (consume) begin
            m_qv = 1'b0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("shreg_lsb",   64'(shreg_a),   64'(exp_shreg(1'b1)));
      chk("shreg_msb",   64'(shreg_b),   64'(exp_shreg(1'b0)));
      chk("bit_cnt_lsb", 64'(bit_cnt_a), 64'(m_cnt));
      chk("bit_cnt_msb", 64'(bit_cnt_b), 64'(m_cnt));
      chk("q_lsb",       64'(q_a),       64'(m_qa));
      chk("q_msb",       64'(q_b),       64'(m_qb));
      chk("q_valid_lsb", 64'(q_valid_a), 64'(m_qv));
      chk("q_valid_msb", 64'(q_valid_b), 64'(m_qv));
      chk("overrun_lsb", 64'(overrun_a), 64'(m_ov));
      chk("overrun_msb", 64'(overrun_b), 64'(m_ov));
   endtask

   // Drive one cycle of inputs, advance the model at the edge, check 1 time unit later.
   task automatic step(input logic r, input logic c, input logic dd,
                       input logic de, input logic qr);
      rst = r; clr = c; d = dd; d_en = de; q_ready = qr;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   // Send a word LSB first (bit 0 of w first); q_ready is applied on the last bit only.
   task automatic feed_word(input logic [W-1:0] w, input logic rdy_last);
      for (int i = 0; i < W; i++) begin
         step(1'b0, 1'b0, w[i], 1'b1, (i == W-1) ? rdy_last : 1'b0);
      end
   endtask

   logic [W-1:0] pat;

   // Directed scenarios followed by a randomized run.
   initial begin
      pat = 8'hA5;

      // Reset held for two cycles with d/d_en toggling.
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("rst_q_valid", 64'(q_valid_a), 64'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_shreg", 64'(shreg_a), 64'd0);

      // A5 streamed LSB first; both instances see bits 1,0,1,0,0,1,0,1.
      step(1'b0, 1'b0, pat[0], 1'b1, 1'b0);
      chk("shreg_e1", 64'(shreg_a), 64'h80);
      step(1'b0, 1'b0, pat[1], 1'b1, 1'b0);
      chk("shreg_e2", 64'(shreg_a), 64'h40);
      step(1'b0, 1'b0, pat[2], 1'b1, 1'b0);
      chk("shreg_e3", 64'(shreg_a), 64'hA0);
      for (int i = 3; i < W; i++) step(1'b0, 1'b0, pat[i], 1'b1, 1'b0);
      chk("a5_lsb_q", 64'(q_a), 64'hA5);
      chk("a5_msb_q", 64'(q_b), 64'hA5);
      chk("a5_bit_cnt", 64'(bit_cnt_a), 64'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // consume

      // Same word with idle gaps in d_en.
      for (int i = 0; i < W; i++) begin
         step(1'b0, 1'b0, pat[i], 1'b1, 1'b0);
         if (i % 3 == 1) step(1'b0, 1'b0, ~pat[i], 1'b0, 1'b0);
      end
      chk("gap_msb_q", 64'(q_b), 64'hA5);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Backpressure: two words without q_ready.
      feed_word(8'h3C, 1'b0);
      feed_word(8'hC3, 1'b0);
      chk("ovr_q", 64'(q_a), 64'hC3);
      chk("ovr_flag", 64'(overrun_a), 64'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovr_sticky", 64'(overrun_a), 64'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("ovr_clr", 64'(overrun_a), 64'd0);

      // Consume exactly on the edge completing the second word.
      feed_word(8'h5A, 1'b0);
      feed_word(8'h96, 1'b1);
      chk("coc_q", 64'(q_a), 64'h96);
      chk("coc_valid", 64'(q_valid_a), 64'd1);
      chk("coc_ovr", 64'(overrun_a), 64'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Flush mid-word with d_en high, then a clean word.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("clr_cnt", 64'(bit_cnt_a), 64'd0);
      chk("clr_shreg", 64'(shreg_a), 64'd0);
      feed_word(8'h71, 1'b0);
      chk("clr_word", 64'(q_a), 64'h71);

      // Reset mid-word also drops q_valid.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("rstmid_valid", 64'(q_valid_a), 64'd0);
      feed_word(8'hE4, 1'b0);
      chk("rstmid_word", 64'(q_a), 64'hE4);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 49) == 0),
              1'($urandom()),
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) < 4));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sipo_deserializer_param.md
# sipo_deserializer_param

Parametrised serial-in/parallel-out deserializer: shifts one serial bit per enabled clock into a WIDTH-bit shift register, counts bits, and on every WIDTH-th accepted bit captures the complete word into a holding register with a valid/ready handshake. It is the general-width, bit-order-selectable successor to the fixed 3-bit SIPO register, and adds:

- framing
- overrun detection
- partial-word flush

It sits between a serial front end (bit stream plus enable) and word-oriented logic downstream.

## Interface
- `WIDTH`, default 8: word width in bits, legal range 2..64.
- `LSB_FIRST`, default 1:
  - 1: first received bit lands in `q[0]`, new bits enter at the MSB and shift toward the LSB.
  - 0: first received bit lands in `q[WIDTH-1]`, new bits enter at the LSB and shift toward the MSB.
- Derived constant `CW = $clog2(WIDTH)`.

Ports:
- `clk`  in  1: rising-edge clock; the block's only clock.
- `rst`  in  1: reset; synchronous, active-high.
- `d`  in  1: serial data bit.
- `d_en`  in  1: accept `d` this cycle.
- `clr`  in  1: synchronous flush of the partial word.
- `q_ready`  in  1: downstream accepts `q` this cycle.
- `shreg`  out  WIDTH: live shift-register contents.
- `bit_cnt`  out  CW: number of bits of the current partial word accepted so far (0..WIDTH-1).
- `q`  out  WIDTH: captured word.
- `q_valid`  out  1: `q` holds an unconsumed word.
- `overrun`  out  1: sticky flag; a word was captured while the previous one was still unconsumed.

## Operation
- **Reset** (`rst`=1 at a rising edge, highest priority):
  - `shreg`=0, `bit_cnt`=0, `q`=0, `q_valid`=0, `overrun`=0.
- **Flush** (`clr`=1, `rst`=0):
  - `shreg`=0, `bit_cnt`=0, `overrun`=0.
  - `d_en` is ignored that cycle; the bit is discarded.
  - `q` and `q_valid` are unaffected; the handshake on `q_ready` still operates.
- **Shift** (`d_en`=1, no `rst`/`clr`):
  - `LSB_FIRST`=1: `shreg` <= {`d`, `shreg[WIDTH-1:1]`}.
  - `LSB_FIRST`=0: `shreg` <= {`shreg[WIDTH-2:0]`, `d`}.
  - `bit_cnt` increments.
- **Word complete**: `d_en`=1 with `bit_cnt`==WIDTH-1.
  - `q` <= the post-shift value of `shreg`, including the current bit.
  - `bit_cnt` wraps to 0 and `q_valid` <= 1.
  - `shreg` is not cleared; it keeps shifting on the next word.
- **Handshake**:
  - A word is consumed when `q_valid` && `q_ready` at the edge; `q_valid` falls the next cycle unless a new word completes at the same edge.
  - `q_ready` with `q_valid`=0 has no effect.
- **Simultaneous consume and complete**:
  - `q_valid` stays 1 and `q` takes the new word.
  - `overrun` is not set.
- **Overrun**:
  - Triggered when a word completes while `q_valid`=1 and `q_ready`=0.
  - `q` is overwritten with the new word (newest data wins), `q_valid` stays 1, and `overrun` <= 1.
  - `overrun` holds until `rst` or `clr`.
- **Idle**: `d_en`=0 leaves `shreg` and `bit_cnt` unchanged.

## Timing
- Every register updates only on the `clk` rising edge; no combinational path from inputs to outputs.
- `shreg` and `bit_cnt` reflect an accepted bit one cycle after its edge.
- **Latency**: `q`/`q_valid` update at the same edge that accepts the WIDTH-th bit, so the word is visible the cycle after that bit is presented.
- **Throughput**: one bit per cycle with `d_en` held high, giving one word per WIDTH cycles.
- `d_en` may have arbitrary gaps; framing depends only on the count of accepted bits.
- **Reset or `clr` mid-word**: partial bits are lost, and the next accepted bit is bit 0 of a new word.

## Test plan
- **Reset values**: assert `rst` for 2 cycles with `d`/`d_en` toggling.
  - All outputs 0 after the first reset edge.
  - No `q_valid` during reset.
- **LSB-first capture** (`WIDTH`=8, `LSB_FIRST`=1): feed bits 1,0,1,0,0,1,0,1 with `d_en` high.
  - After the 8th edge: `q`=8'hA5, `q_valid`=1, `bit_cnt`=0.
  - `shreg` sequence 8'h80, 8'h40, 8'hA0, … on successive edges.
- **MSB-first capture** (`LSB_FIRST`=0): same bit sequence.
  - `q`=8'hA5 after the 8th bit.
  - Inserting idle cycles in `d_en` gives the same result one cycle later per gap.
- **Backpressure/overrun**: hold `q_ready`=0 and stream two words 8'h3C then 8'hC3.
  - After the second word: `q`=8'hC3, `q_valid`=1, `overrun`=1.
  - `overrun` stays 1 after `q_ready` pulses, and clears on a `clr` pulse.
- **Consume-on-complete**: pulse `q_ready` exactly at the edge completing the second word.
  - `q_valid` stays 1, `q` = second word, `overrun`=0.
- **Flush/reset mid-word**:
  - After 5 bits, pulse `clr` with `d_en`=1: `bit_cnt`=0, `shreg`=0, and the next 8 bits form a clean word.
  - Repeating with `rst` mid-word additionally clears `q_valid`.
